// File: rtl/shared_unit_arbiter_pkg.sv
// Shared definitions for the shared-unit arbiter: tag width helper,
// requester limit and the tracking-pipeline stage record.
package shared_arb_pkg;

   localparam int ARB_MAX_REQ = 16;

   // Width of a requester index; never narrower than one bit.
   function automatic int tag_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Stage records carry tags at the widest width any build can need,
   // so one struct type serves every N_REQ.
   localparam int TAG_W_MAX = tag_w(ARB_MAX_REQ);

   typedef struct packed {
      logic                 vld;
      logic [TAG_W_MAX-1:0] tag;
   } stage_t;

endpackage

// File: rtl/shared_unit_arbiter_if.sv
// Request/result handshake bundle between requesters and the arbiter.
// slave: arbiter side; master: requester side.
interface shared_unit_arbiter_if #(parameter int N_REQ = 4);
   import shared_arb_pkg::*;

   localparam int TAG_W = tag_w(N_REQ);

   logic [N_REQ-1:0] req_valid;
   logic [N_REQ-1:0] req_ready;
   logic [TAG_W-1:0] op_sel;
   logic             op_valid;
   logic             pipe_en;
   logic [N_REQ-1:0] res_valid;
   logic [N_REQ-1:0] res_ready;

   modport slave (
      input  req_valid, res_ready,
      output req_ready, op_sel, op_valid, pipe_en, res_valid
   );

   modport master (
      output req_valid, res_ready,
      input  req_ready, op_sel, op_valid, pipe_en, res_valid
   );

endinterface

// File: rtl/shared_unit_arbiter_rr_arbiter.sv
// Single-grant arbiter. Round-robin starting at ptr by default; with
// SHARED_ARB_FIXED_PRIO_EN defined it is fixed priority (lowest index
// wins) and the ptr input does not exist.
module rr_arbiter
   import shared_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int TAG_W = tag_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic             en,
`ifndef SHARED_ARB_FIXED_PRIO_EN
   input  logic [TAG_W-1:0] ptr,
`endif
   output logic [N_REQ-1:0] gnt,
   output logic [TAG_W-1:0] idx
);

   logic found;
   int   j;

   // First requesting index in search order wins; nothing when disabled.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      if (en) begin
         for (int k = 0; k < N_REQ; k++) begin
`ifdef SHARED_ARB_FIXED_PRIO_EN
            j = k;
`else
            j = (int'(ptr) + k) % N_REQ;
`endif
            if (!found && req[j]) begin
               found  = 1'b1;
               gnt[j] = 1'b1;
               idx    = TAG_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/shared_unit_arbiter.sv
// Time-multiplexes one fixed-latency pipelined unit among N_REQ
// requesters and routes each result back to its owner. The whole
// tracking pipeline stalls when the tail result is not accepted.
// Build option: SHARED_ARB_FIXED_PRIO_EN selects fixed priority.
module shared_unit_arbiter
   import shared_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int LATENCY = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   shared_unit_arbiter_if.slave bus
);

   localparam int TAG_W = tag_w(N_REQ);

   stage_t           pipe_q [LATENCY];
   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] tail_hit;
   logic [TAG_W-1:0] gnt_idx;
   logic             pipe_en;
   logic             arb_en;

   // Decode the tail stage into a one-hot owner vector.
   always_comb begin
      tail_hit = '0;
      for (int i = 0; i < N_REQ; i++) begin
         tail_hit[i] = pipe_q[LATENCY-1].vld &&
                       (pipe_q[LATENCY-1].tag == TAG_W_MAX'(i));
      end
   end

   // An empty tail never blocks; a full one needs its owner's ready.
   assign pipe_en = rst || !pipe_q[LATENCY-1].vld || (|(tail_hit & bus.res_ready));
   assign arb_en  = pipe_en && !rst;

   assign bus.pipe_en   = pipe_en;
   assign bus.req_ready = gnt;
   assign bus.op_valid  = |gnt;
   assign bus.op_sel    = gnt_idx;
   assign bus.res_valid = rst ? '0 : tail_hit;

`ifndef SHARED_ARB_FIXED_PRIO_EN
   logic [TAG_W-1:0] ptr;

   // Search restarts just past the most recent winner.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (|gnt) begin
         ptr <= (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
      end
   end
`endif

   rr_arbiter #(
      .N_REQ (N_REQ),
      .TAG_W (TAG_W)
   ) u_arb (
      .req (bus.req_valid),
      .en  (arb_en),
`ifndef SHARED_ARB_FIXED_PRIO_EN
      .ptr (ptr),
`endif
      .gnt (gnt),
      .idx (gnt_idx)
   );

   // Tracking pipeline advances in lockstep with the shared unit.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LATENCY; k++) begin
            pipe_q[k] <= '0;
         end
      end else if (pipe_en) begin
         pipe_q[0] <= {bus.op_valid, TAG_W_MAX'(gnt_idx)};
         for (int k = 1; k < LATENCY; k++) begin
            pipe_q[k] <= pipe_q[k-1];
         end
      end
   end

endmodule

// File: tb/tb_shared_unit_arbiter.sv
// Directed bench for shared_unit_arbiter (N_REQ=4, LATENCY=8) with a
// result scoreboard: issues push {owner, accept cycle}, a monitor pops
// on every accepted result.
module tb_shared_unit_arbiter;

   localparam int LAT = 8;
`ifdef SHARED_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      int tag;
      int cyc;
   } exp_t;
   exp_t sb[$];

   shared_unit_arbiter_if #(.N_REQ(4)) bus ();

   shared_unit_arbiter #(.N_REQ(4), .LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // One cycle: drive inputs, check arbitration outputs, log expected result.
   task automatic step(input logic r, input logic [3:0] rv, input logic [3:0] rr,
                       input logic exp_ov, input int exp_sel, input logic exp_pe,
                       input int delay);
      @(posedge clk);
      #1;
      rst           = r;
      bus.req_valid = rv;
      bus.res_ready = rr;
      @(negedge clk);
      chk("op_valid", int'(bus.op_valid), int'(exp_ov));
      chk("op_sel", int'(bus.op_sel), exp_ov ? exp_sel : 0);
      chk("req_ready", int'(bus.req_ready), exp_ov ? (1 << exp_sel) : 0);
      chk("pipe_en", int'(bus.pipe_en), int'(exp_pe));
      if (r) chk("res_valid_in_rst", int'(bus.res_valid), 0);
      if (exp_ov) sb.push_back('{exp_sel, cyc + LAT + delay});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'hF, 1'b0, 0, 1'b1, 0);
   endtask

   // Monitor: every accepted result must match the oldest expected one.
   always @(negedge clk) begin
      if (!rst && bus.res_valid != 4'h0) begin
         chk("res_onehot", int'($onehot(bus.res_valid)), 1);
         if ((bus.res_valid & bus.res_ready) != 4'h0) begin
            if (sb.size() == 0) begin
               chk("res_unexpected", int'(bus.res_valid), 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("res_owner", int'(bus.res_valid), 1 << e.tag);
               chk("res_cycle", cyc, e.cyc);
            end
         end
      end
   end

   int tt;
   int mid[6] = '{2, 3, 1, 2, 3, 1};

   initial begin
      bus.req_valid = 4'h0;
      bus.res_ready = 4'h0;
      tt = FIXED ? 0 : 3;

      // reset held with requests pending: nothing granted
      repeat (3) step(1'b1, 4'hF, 4'hF, 1'b0, 0, 1'b1, 0);
      // idle after reset
      idle(20);

      // round-robin fairness from ptr=0
      for (int i = 0; i < 8; i++) step(1'b0, 4'hF, 4'hF, 1'b1, FIXED ? 0 : i % 4, 1'b1, 0);
      idle(10);

      // single issue from requester 2 (ptr -> 3)
      step(1'b0, 4'b0100, 4'hF, 1'b1, 2, 1'b1, 0);
      idle(10);

      // back-pressure: fill, then hold the tail owner's ready low 5 cycles
      for (int i = 0; i < 8; i++) step(1'b0, 4'hF, 4'hF, 1'b1, FIXED ? 0 : (3 + i) % 4, 1'b1, 5);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'hF, 4'hF & ~(4'h1 << tt), 1'b0, 0, 1'b0, 0);
         chk("res_hold", int'(bus.res_valid), 1 << tt);
      end
      // resume: accept at tail and issue in the same cycle
      for (int i = 0; i < 4; i++) step(1'b0, 4'hF, 4'hF, 1'b1, FIXED ? 0 : (3 + i) % 4, 1'b1, 0);
      idle(12);

      // bubble pass-through with all result readies low (ptr=3 -> 1)
      step(1'b0, 4'b0010, 4'h0, 1'b1, 1, 1'b1, 1);
      for (int i = 0; i < 7; i++) step(1'b0, 4'h0, 4'h0, 1'b0, 0, 1'b1, 0);
      step(1'b0, 4'h0, 4'h0, 1'b0, 0, 1'b0, 0);
      chk("bubble_res", int'(bus.res_valid), 4'b0010);
      step(1'b0, 4'h0, 4'hF, 1'b0, 0, 1'b1, 0);
      idle(3);

      // reset mid-flight: six ops in flight, ptr left at 2
      for (int i = 0; i < 6; i++) step(1'b0, 4'hE, 4'hF, 1'b1, FIXED ? 1 : mid[i], 1'b1, 0);
      step(1'b1, 4'hE, 4'hF, 1'b0, 0, 1'b1, 0);
      sb.delete();
      idle(12);
      // ptr back to 0: lowest valid requester wins
      step(1'b0, 4'b0110, 4'hF, 1'b1, 1, 1'b1, 0);
      idle(10);

      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shared_unit_arbiter.md
# shared_unit_arbiter

Time-multiplexes one fixed-latency, fully pipelined functional unit (e.g. a shared multiplier or divider) among N_REQ elastic requesters. Each cycle it picks at most one requester round-robin, drives the unit's operand-mux select, and issues the operation. It tracks every in-flight operation in a valid/tag shift pipeline and returns each result to its originating requester with a valid/ready handshake. The whole pipeline stalls as a unit when the result at its tail is not accepted.

## Interface
- N_REQ, 4: number of requesters; 2..16.
- LATENCY, 8: shared-unit latency in cycles; ≥1; equals the depth of the tracking pipeline.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  one-hot grant/accept; at most one bit set.
- op_sel  out  TAG_W  index of the granted requester (operand mux select); TAG_W = max(1, clog2(N_REQ)).
- op_valid  out  1  an operation enters the unit this cycle.
- pipe_en  out  1  clock enable for the shared unit's internal registers.
- res_valid  out  N_REQ  one-hot result valid for the owning requester.
- res_ready  in  N_REQ  per-requester result ready.

## Operation
- Tracking pipeline: LATENCY stages of {vld, tag}. Stage 0 loads {op_valid, op_sel}. Stage k loads stage k-1 when pipe_en is high and holds otherwise.
- Tail = stage LATENCY-1. res_valid[i] = tail.vld && tail.tag==i.
- pipe_en = !tail.vld || res_ready[tail.tag]. Empty bubbles never block the pipeline.
- Grant: only when pipe_en && !rst. Priority search starts at ptr and wraps modulo N_REQ. The first i with req_valid[i] gets req_ready[i]=1, op_valid=1, op_sel=i.
- No grant: op_valid=0 and op_sel=0. Stage 0 then loads a bubble if pipe_en is high.
- ptr update: after a grant to i, ptr ← (i+1) mod N_REQ. Otherwise ptr holds.
- req_ready and res_valid are combinational from state and inputs. There is no req_valid→req_ready dependence beyond the arbitration itself, and no res_ready→req_ready path except through pipe_en.
- Reset: all vld bits cleared, tags cleared, ptr=0. While rst is high: req_ready=0, op_valid=0, op_sel=0, res_valid=0, pipe_en=1.
- Reset mid-operation: all in-flight results are discarded. No res_valid is asserted for them after reset.

## Timing
- Latency: accept at cycle t → res_valid at t+LATENCY when there are no stalls. Each stalled cycle adds one cycle.
- Throughput: one issue per cycle while results are consumed.
- Stall cycle (pipe_en=0):
  - No grant.
  - All stages hold.
  - res_valid stays asserted until accepted.
- Simultaneous accept of tail result and new issue in the same cycle is allowed and required.
- Requester i with req_valid held continuously waits at most N_REQ-1 grant opportunities.

## Configuration
- SHARED_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest index wins, and ptr is removed.
  - Undefined: round-robin as above.
- All other behaviour is identical in both modes.

## Structure
- Package shared_arb_pkg holds:
  - tag-width function (max(1, clog2(n)));
  - ARB_MAX_REQ=16 constant;
  - packed stage struct type {vld, tag} parameterised via TAG_W constant helper.
- Sub-module rr_arbiter: inputs req[N_REQ], en, ptr; outputs one-hot gnt and index. It contains the fixed-priority variant under the macro. The tracking pipeline and ptr register stay in the top module.

## Test plan
- Reset/idle: N_REQ=4, LATENCY=8, all req_valid=0 for 20 cycles after rst.
  - Required: res_valid=0, pipe_en=1, op_valid=0 throughout.
- Single issue: req_valid=4'b0100 for one accept at cycle 10, res_ready=all 1.
  - Required: op_sel=2 at cycle 10, res_valid=4'b0100 exactly at cycle 18 for one cycle.
- Round-robin fairness: req_valid=4'b1111 held, res_ready=1.
  - Required: grant sequence 0,1,2,3,0,… one per cycle.
  - Required: results return in the same order 8 cycles later.
  - With SHARED_ARB_FIXED_PRIO_EN: only requester 0 is ever granted.
- Back-pressure: fill the pipeline, then res_ready[tail tag]=0 for 5 cycles.
  - Required: pipe_en=0, req_ready=0, res_valid held stable for 5 cycles.
  - Required: no result lost or duplicated afterwards.
  - Required: every result arrives 5 cycles late.
- Bubble pass-through: tail empty while res_ready=0 everywhere.
  - Required: pipe_en=1, issue proceeds.
- Reset mid-flight: 6 operations in flight, rst for 1 cycle.
  - Required: no res_valid afterwards until new issues, ptr=0 (next grant goes to the lowest valid requester).
